hall_conditioner: RTL and testbench



---
 rtl/hall_conditioner.sv | 109 ++++++++++
 tb/tb_hall_conditioner.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hall_conditioner.sv
// hall_conditioner: synchronize, debounce and sequence-check BLDC hall inputs, measure step period
// Ports: clock/reset (sync, active-high); hall_raw async sensor bits; fault_clear clears sticky fault;
// hall_out/hall_valid debounced code; step_strobe/direction per legal step; period/period_valid
// cycles between steps; stalled when no step for 2^PERIOD_WIDTH-1 cycles; fault sticky sequence error.
module hall_conditioner #(
  parameter int FILTER_LEN   = 16,
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2:0]              hall_raw,
  input  logic                    fault_clear,
  output logic [2:0]              hall_out,
  output logic                    hall_valid,
  output logic                    step_strobe,
  output logic                    direction,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled,
  output logic                    fault
);
  localparam logic [PERIOD_WIDTH-1:0] PMAX    = '1;
  localparam logic [7:0]              CNT_END = 8'(FILTER_LEN - 1);
  function automatic logic [2:0] fwd(input logic [2:0] c);
    case (c)
      3'b101:  fwd = 3'b100;
      3'b100:  fwd = 3'b110;
      3'b110:  fwd = 3'b010;
      3'b010:  fwd = 3'b011;
      3'b011:  fwd = 3'b001;
      3'b001:  fwd = 3'b101;
      default: fwd = 3'b000;
    endcase
  endfunction
  function automatic logic legal(input logic [2:0] c);
    return c != 3'b000 && c != 3'b111;
  endfunction
  logic [2:0]              s1_q, s1_d, s2_q, s2_d, cand_q, cand_d, hall_q, hall_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d, period_q, period_d;
  logic                    step_q, step_d, dir_q, dir_d, pv_q, pv_d, stalled_q, stalled_d;
  logic                    fault_q, fault_d, last_ok_q, last_ok_d;
  logic                    accept, prev_ok, new_ok, is_fwd, is_rev, strobe, bad, skip, seed;
  always_comb begin
    s1_d    = hall_raw;
    s2_d    = s1_q;
    accept  = s2_q == cand_q && cnt_q == CNT_END && cand_q != hall_q;
    cand_d  = s2_q;
    cnt_d   = s2_q != cand_q ? 8'd0 : accept ? cnt_q : cnt_q + 8'(cnt_q != 8'hff);
    hall_d  = accept ? cand_q : hall_q;
    prev_ok = legal(hall_q);
    new_ok  = legal(cand_q);
    // a legal previous code is required for adjacency; fwd() of an illegal code is 000
    is_fwd  = accept && prev_ok && cand_q == fwd(hall_q);
    is_rev  = accept && prev_ok && hall_q == fwd(cand_q);
    strobe  = is_fwd | is_rev;
    bad     = accept && !new_ok;
    skip    = accept && prev_ok && new_ok && !strobe;
    seed    = accept && !prev_ok && new_ok;
    pcnt_d  = (strobe | skip | seed) ? PERIOD_WIDTH'(1) : pcnt_q + PERIOD_WIDTH'(pcnt_q != PMAX);
    step_d  = strobe;
    dir_d   = strobe ? is_fwd : dir_q;
    period_d = strobe ? pcnt_q : period_q;
    // the first step after a stall reports its period but never as valid
    pv_d    = strobe ? last_ok_q & ~stalled_q : (bad | skip | seed | pcnt_d == PMAX) ? 1'b0 : pv_q;
    stalled_d = strobe ? 1'b0 : pcnt_d == PMAX ? 1'b1 : stalled_q;
    last_ok_d = (strobe | seed) ? 1'b1 : (bad | skip) ? 1'b0 : last_ok_q;
    fault_d = bad | skip | (fault_q & ~fault_clear);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      hall_q    <= '0;
      pcnt_q    <= '0;
      period_q  <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      pv_q      <= 1'b0;
      stalled_q <= 1'b0;
      fault_q   <= 1'b0;
      last_ok_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      hall_q    <= hall_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      pv_q      <= pv_d;
      stalled_q <= stalled_d;
      fault_q   <= fault_d;
      last_ok_q <= last_ok_d;
    end
  end
  assign hall_out     = hall_q;
  assign hall_valid   = legal(hall_q);
  assign step_strobe  = step_q;
  assign direction    = dir_q;
  assign period       = period_q;
  assign period_valid = pv_q;
  assign stalled      = stalled_q;
  assign fault        = fault_q;
endmodule

// File: tb/tb_hall_conditioner.sv
// tb_hall_conditioner: random and directed hall sequences checked against a behavioural model
module tb_hall_conditioner;
  localparam int F = 16;
  localparam int W = 8;
  localparam int MAXP = (1 << W) - 1;
  logic         clock = 1'b0, reset = 1'b1, fault_clear = 1'b0;
  logic [2:0]   hall_raw = 3'b000, hall_out;
  logic         hall_valid, step_strobe, direction, period_valid, stalled, fault;
  logic [W-1:0] period;
  hall_conditioner #(.FILTER_LEN(F), .PERIOD_WIDTH(W)) dut (
    .clock(clock), .reset(reset), .hall_raw(hall_raw), .fault_clear(fault_clear),
    .hall_out(hall_out), .hall_valid(hall_valid), .step_strobe(step_strobe),
    .direction(direction), .period(period), .period_valid(period_valid),
    .stalled(stalled), .fault(fault)
  );
  always #5 clock = ~clock;
  int n_chk = 0, n_pass = 0, t = 0, ev = 0;
  int seq [6] = '{5, 4, 6, 2, 3, 1};
  logic [2:0] q [$];
  logic [2:0] m_hall;
  logic       m_step, m_dir, m_pv, m_stall, m_fault, m_last_ok;
  int         m_period;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
  endtask
  function automatic int pos(input logic [2:0] c);
    for (int k = 0; k < 6; k++) if (seq[k] == int'(c)) return k;
    return -1;
  endfunction
  function automatic int imin(input int a, input int b);
    return a < b ? a : b;
  endfunction
  // one clock: apply inputs, advance the model by its rules, compare every output
  task automatic cyc(input logic [2:0] raw, input logic fc, input logic r);
    logic [2:0] v;
    logic acc, strobe;
    int pp, pn;
    @(negedge clock);
    hall_raw = raw; fault_clear = fc; reset = r;
    @(posedge clock);
    t++;
    if (r) begin
      q.delete();
      repeat (F + 2) q.push_back(3'b000);
      {m_hall, m_step, m_dir, m_pv, m_stall, m_fault, m_last_ok} = '0;
      m_period = 0;
      ev = t + 1;
    end else begin
      // accept once F+1 consecutive synchronized samples agree on a code differing from hall_out
      v = q[q.size() - 2];
      acc = v != m_hall;
      for (int i = 2; i <= F + 2; i++) if (q[q.size() - i] != v) acc = 0;
      strobe = 0;
      m_fault = m_fault & ~fc;
      if (acc) begin
        pp = pos(m_hall);
        pn = pos(v);
        if (pp >= 0 && pn == (pp + 1) % 6) begin strobe = 1; m_dir = 1; end
        else if (pp >= 0 && pn == (pp + 5) % 6) begin strobe = 1; m_dir = 0; end
        else if (pn < 0) begin m_fault = 1; m_pv = 0; m_last_ok = 0; end
        else if (pp >= 0) begin m_fault = 1; m_pv = 0; m_last_ok = 0; ev = t; end
        else begin m_pv = 0; m_last_ok = 1; ev = t; end
        m_hall = v;
      end
      if (strobe) begin
        m_period = imin(t - ev, MAXP);
        m_pv = m_last_ok & ~m_stall;
        m_stall = 0;
        m_last_ok = 1;
        ev = t;
      end else if (imin(t - ev + 1, MAXP) == MAXP) begin
        m_stall = 1;
        m_pv = 0;
      end
      m_step = strobe;
      q.push_back(raw);
      if (q.size() > F + 4) void'(q.pop_front());
    end
    #1;
    chk("hall_out", hall_out, m_hall);
    chk("hall_valid", hall_valid, pos(m_hall) >= 0);
    chk("step_strobe", step_strobe, m_step);
    chk("direction", direction, m_dir);
    chk("period", period, m_period);
    chk("period_valid", period_valid, m_pv);
    chk("stalled", stalled, m_stall);
    chk("fault", fault, m_fault);
  endtask
  task automatic hold(input logic [2:0] v, input int n, input int fc_at = -1);
    for (int i = 0; i < n; i++) cyc(v, i == fc_at, 1'b0);
  endtask
  initial begin
    int idx;
    logic [2:0] nxt;
    repeat (3) cyc(3'b000, 1'b0, 1'b1);
    hold(3'b101, 60);
    for (int k = 1; k <= 12; k++) hold(3'(seq[k % 6]), $urandom_range(20, 240));
    hold(3'b001, 80);
    hold(3'b011, 80);
    hold(3'b010, 60);
    hold(3'b110, 60);
    hold(3'b100, 60);
    hold(3'b110, 10);
    hold(3'b100, 60);
    hold(3'b110, 17);
    hold(3'b100, 60);
    hold(3'b110, 60);
    hold(3'b111, 60);
    hold(3'b101, 60);
    hold(3'b110, 60);
    hold(3'b110, 30, 5);
    hold(3'b001, 60, F + 2);
    hold(3'b001, 20, 3);
    hold(3'b101, 60);
    hold(3'b100, 60);
    hold(3'b110, 60);
    hold(3'b010, 320);
    hold(3'b011, 60);
    hold(3'b001, 60);
    hold(3'b101, 60);
    for (int s = 0; s < 80; s++) begin
      idx = pos(m_hall);
      if (idx < 0 || $urandom_range(0, 9) == 0) nxt = 3'($urandom_range(0, 7));
      else nxt = 3'(seq[$urandom_range(0, 1) == 1 ? (idx + 1) % 6 : (idx + 5) % 6]);
      if ($urandom_range(0, 5) == 0) hold(3'($urandom_range(0, 7)), $urandom_range(1, F));
      if ($urandom_range(0, 24) == 0) repeat (2) cyc(nxt, 1'b0, 1'b1);
      hold(nxt, $urandom_range(0, 12) == 0 ? 300 : $urandom_range(F + 3, 200),
           $urandom_range(0, 3) == 0 ? $urandom_range(0, F + 4) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
